// File: rtl/npu_pkg.sv
// Shared NPU definitions: default datapath widths and the PISO serializer state encoding.
package npu_pkg;

  localparam int unsigned NPU_ACC_W  = 16;
  localparam int unsigned NPU_BYTE_W = 8;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_out_stream.sv
// Output serializer: captures NUM_CH x CH_W results per load and streams them as
// OUT_W-bit beats over valid/ready, with selectable beat order and zero-bubble reloads.
module piso_out_stream
  import npu_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = NPU_ACC_W,
  parameter int unsigned OUT_W  = NPU_BYTE_W,
  localparam int unsigned TOT_W = NUM_CH * CH_W,
  localparam int unsigned BEATS = TOT_W / OUT_W,
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             CLKEXT,
  input  logic             RST_GLO,
  input  logic             CLR_PISO_OUT,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [TOT_W-1:0] mac_in,
  input  logic             MSB_FIRST,
  output logic [OUT_W-1:0] D_OUT,
  output logic             D_VALID,
  input  logic             D_READY,
  output logic             D_LAST,
  output logic             BUSY
);

  if ((CH_W % OUT_W) != 0 || BEATS < 1) begin : g_param_check
    $error("piso_out_stream: CH_W must be a multiple of OUT_W and BEATS >= 1");
  end

  piso_state_e      state;
  logic [TOT_W-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             order;

  logic shift_st;
  logic last_beat;
  logic load_fire;
  logic beat_fire;

  assign shift_st  = (state == PISO_SHIFT);
  assign last_beat = shift_st && (cnt == '0);
  assign beat_fire = shift_st && D_READY;

  // Ready on the final accepted beat lets the next load follow without a gap.
  assign LOAD_READY = !CLR_PISO_OUT && (!shift_st || (last_beat && D_READY));
  assign load_fire  = LOAD_VALID && LOAD_READY;

  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      state <= PISO_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      order <= 1'b0;
    end else if (CLR_PISO_OUT) begin
      state <= PISO_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      order <= 1'b0;
    end else if (load_fire) begin
      state <= PISO_SHIFT;
      sreg  <= mac_in;
      order <= MSB_FIRST;
      cnt   <= CNT_W'(BEATS - 1);
    end else if (beat_fire) begin
      if (cnt != '0) begin
        // Move the next beat into the output slice; the vacated end fills with zeros.
        sreg <= order ? (sreg << OUT_W) : (sreg >> OUT_W);
        cnt  <= cnt - CNT_W'(1);
      end else begin
        state <= PISO_IDLE;
        sreg  <= '0;
      end
    end
  end

  assign D_OUT   = !shift_st ? '0 :
                   (order ? sreg[TOT_W-1 -: OUT_W] : sreg[OUT_W-1:0]);
  assign D_VALID = shift_st;
  assign D_LAST  = last_beat;
  assign BUSY    = shift_st;

endmodule

// File: tb/tb_piso_out_stream.sv
// Bench for piso_out_stream: directed vector table, reset/clear/reparam sequences,
// and randomized traffic against a queue-of-beats reference model.
module tb_piso_out_stream;

  localparam int unsigned TOT_W = 32;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned BEATS = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             lv;
  logic [TOT_W-1:0] mac;
  logic             msb;
  logic             dr;

  logic             lr_a, v_a, last_a, busy_a;
  logic [OUT_W-1:0] out_a;
  logic             lr_b, v_b, last_b, busy_b;
  logic [OUT_W-1:0] out_b;

  int errors = 0;
  int checks = 0;

  logic [OUT_W-1:0] q[$];

  always #5 clk = ~clk;

  piso_out_stream dut_a (
    .CLKEXT(clk), .RST_GLO(rst), .CLR_PISO_OUT(clr), .LOAD_VALID(lv), .LOAD_READY(lr_a),
    .mac_in(mac), .MSB_FIRST(msb), .D_OUT(out_a), .D_VALID(v_a), .D_READY(dr),
    .D_LAST(last_a), .BUSY(busy_a)
  );

  piso_out_stream #(.NUM_CH(4), .CH_W(8), .OUT_W(8)) dut_b (
    .CLKEXT(clk), .RST_GLO(rst), .CLR_PISO_OUT(clr), .LOAD_VALID(lv), .LOAD_READY(lr_b),
    .mac_in(mac), .MSB_FIRST(msb), .D_OUT(out_b), .D_VALID(v_b), .D_READY(dr),
    .D_LAST(last_b), .BUSY(busy_b)
  );

  typedef struct {
    logic             lv;
    logic [TOT_W-1:0] mac;
    logic             msb;
    logic             dr;
    logic             clr;
    logic [OUT_W-1:0] e_out;
    logic             e_v;
    logic             e_last;
    logic             e_lr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic lv_i, input logic [TOT_W-1:0] mac_i, input logic msb_i,
                      input logic dr_i, input logic clr_i, input logic [OUT_W-1:0] eo,
                      input logic ev, input logic el, input logic elr);
    vec_t v;
    v.lv = lv_i; v.mac = mac_i; v.msb = msb_i; v.dr = dr_i; v.clr = clr_i;
    v.e_out = eo; v.e_v = ev; v.e_last = el; v.e_lr = elr;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic lv_i, input logic [TOT_W-1:0] mac_i, input logic msb_i,
                       input logic dr_i, input logic clr_i);
    lv = lv_i; mac = mac_i; msb = msb_i; dr = dr_i; clr = clr_i;
  endtask

  // Reference: the pending beats of the current load sit in a queue, head = D_OUT.
  function automatic logic model_lr();
    return !clr && (q.size() == 0 || (q.size() == 1 && dr));
  endfunction

  task automatic model_update();
    logic load_ok;
    load_ok = lv && model_lr();
    if (clr) begin
      q.delete();
    end else begin
      if (q.size() > 0 && dr) void'(q.pop_front());
      if (load_ok) begin
        for (int k = 0; k < BEATS; k++) begin
          if (msb) q.push_back(OUT_W'(mac >> (TOT_W - OUT_W * (k + 1))));
          else     q.push_back(OUT_W'(mac >> (OUT_W * k)));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_a"}, 32'(out_a), 32'h0);
    chk({tag, "_valid_a"}, 32'(v_a), 32'h0);
    chk({tag, "_last_a"}, 32'(last_a), 32'h0);
    chk({tag, "_busy_a"}, 32'(busy_a), 32'h0);
    chk({tag, "_lready_a"}, 32'(lr_a), 32'h1);
    chk({tag, "_valid_b"}, 32'(v_b), 32'h0);
    chk({tag, "_out_b"}, 32'(out_b), 32'h0);
  endtask

  localparam logic [TOT_W-1:0] M1 = 32'hA1B2_C3D4;
  localparam logic [TOT_W-1:0] M2 = 32'h1122_3344;

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    //   lv   mac  msb  dr   clr  out    v  last lr
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1);
    // MSB-first stream
    addv(1'b1, M1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hA1, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hB2, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hC3, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hD4, 1, 1, 1);
    // LSB-first stream
    addv(1'b1, M1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 1);
    addv(1'b0, M1, 1'b0, 1'b1, 1'b0, 8'hD4, 1, 0, 0);
    addv(1'b0, M1, 1'b0, 1'b1, 1'b0, 8'hC3, 1, 0, 0);
    addv(1'b0, M1, 1'b0, 1'b1, 1'b0, 8'hB2, 1, 0, 0);
    addv(1'b0, M1, 1'b0, 1'b1, 1'b0, 8'hA1, 1, 1, 1);
    addv(1'b0, M1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 1);
    // Backpressure on B2 and on the last beat
    addv(1'b1, M1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hA1, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b0, 1'b0, 8'hB2, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b0, 1'b0, 8'hB2, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b0, 1'b0, 8'hB2, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hB2, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hC3, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b0, 1'b0, 8'hD4, 1, 1, 0);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hD4, 1, 1, 1);
    // Back-to-back reload on the D_LAST cycle
    addv(1'b1, M1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hA1, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hB2, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hC3, 1, 0, 0);
    addv(1'b1, M2, 1'b1, 1'b1, 1'b0, 8'hD4, 1, 1, 1);
    addv(1'b0, M2, 1'b1, 1'b1, 1'b0, 8'h11, 1, 0, 0);
    addv(1'b0, M2, 1'b1, 1'b1, 1'b0, 8'h22, 1, 0, 0);
    addv(1'b0, M2, 1'b1, 1'b1, 1'b0, 8'h33, 1, 0, 0);
    addv(1'b0, M2, 1'b1, 1'b1, 1'b0, 8'h44, 1, 1, 1);
    addv(1'b0, M2, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1);
    // Clear on C3 with a concurrent load, then clear while idle
    addv(1'b1, M1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hA1, 1, 0, 0);
    addv(1'b0, M1, 1'b1, 1'b1, 1'b0, 8'hB2, 1, 0, 0);
    addv(1'b1, M2, 1'b1, 1'b1, 1'b1, 8'hC3, 1, 0, 0);
    addv(1'b0, M2, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1);
    addv(1'b0, M2, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1);
    addv(1'b1, M2, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0, 0);
    addv(1'b0, M2, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].lv, tbl[i].mac, tbl[i].msb, tbl[i].dr, tbl[i].clr);
      #1;
      chk($sformatf("vec%0d_out", i), 32'(out_a), 32'(tbl[i].e_out));
      chk($sformatf("vec%0d_valid", i), 32'(v_a), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d_last", i), 32'(last_a), 32'(tbl[i].e_last));
      chk($sformatf("vec%0d_lready", i), 32'(lr_a), 32'(tbl[i].e_lr));
      chk($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(tbl[i].e_v));
      tick();
    end

    // Asynchronous reset in the middle of a beat, away from any clock edge
    drive(1'b1, M1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, M1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("pre_rst_out", 32'(out_a), 32'hA1);
    chk("pre_rst_busy", 32'(busy_a), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Rerun on the 4x8 instance, LSB first
    drive(1'b1, 32'h0403_0201, 1'b0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < BEATS; k++) begin
      drive(1'b0, 32'h0403_0201, 1'b0, 1'b1, 1'b0);
      #1;
      chk($sformatf("rerun_b%0d_out", k), 32'(out_b), 32'(k + 1));
      chk($sformatf("rerun_b%0d_valid", k), 32'(v_b), 32'h1);
      chk($sformatf("rerun_b%0d_last", k), 32'(last_b), 32'(k == BEATS - 1));
      tick();
    end
    #1;
    chk("rerun_idle_valid", 32'(v_b), 32'h0);
    chk("rerun_idle_lready", 32'(lr_b), 32'h1);

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
      #1;
      chk("rnd_valid", 32'(v_a), 32'(q.size() > 0));
      chk("rnd_out", 32'(out_a), (q.size() > 0) ? 32'(q[0]) : 32'h0);
      chk("rnd_last", 32'(last_a), 32'(q.size() == 1));
      chk("rnd_lready", 32'(lr_a), 32'(model_lr()));
      chk("rnd_busy", 32'(busy_a), 32'(q.size() > 0));
      chk("rnd_out_b", 32'(out_b), (q.size() > 0) ? 32'(q[0]) : 32'h0);
      chk("rnd_last_b", 32'(last_b), 32'(q.size() == 1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
